playseq_detector_jogada: RTL and testbench

Button front-end of the PlaySeq game: synchronizes the raw `botoes` inputs, debounces presses and releases, and delivers exactly one single-cycle `tem_jogada` pulse per valid single-button press, with the one-hot `jogada` code held stable. It sits directly upstream of `playseq_unidade_controle` and the jogada register. `tem_jogada` drives the control unit's `espera`/`espera_escrita` transitions, and `jogada` feeds the register written on `registraR`.

---
 rtl/playseq_pkg.sv | 17 +
 rtl/playseq_sincronizador.sv | 29 ++
 rtl/playseq_detector_jogada.sv | 144 ++++++++++++++
 tb/tb_playseq_detector_jogada.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/playseq_pkg.sv
// rtl/playseq_pkg.sv - shared PlaySeq constants: FSM encodings and default widths
package playseq_pkg;

    // Number of game buttons; also the jogada register and RAM data width.
    localparam int N_BOTOES_PADRAO = 4;

    // 1 ms at 50 MHz.
    localparam int DEBOUNCE_CICLOS_PADRAO = 50000;

    // Detector FSM encodings, exported unchanged on db_estado.
    localparam logic [2:0] EST_OCIOSO       = 3'd0;
    localparam logic [2:0] EST_FILTRA_PRESS = 3'd1;
    localparam logic [2:0] EST_PULSO        = 3'd2;
    localparam logic [2:0] EST_SEGURA       = 3'd3;
    localparam logic [2:0] EST_FILTRA_SOLTA = 3'd4;

endpackage

// File: rtl/playseq_sincronizador.sv
// rtl/playseq_sincronizador.sv - parameterized-width 2-FF synchronizer
//
// Ports:
//   clock    system clock, rising edge
//   reset    asynchronous active-low reset (clears both stages)
//   entrada  asynchronous input bits
//   saida    synchronized bits, two clock edges behind entrada
module playseq_sincronizador #(
    parameter int LARGURA = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] entrada,
    output logic [LARGURA-1:0] saida
);

    logic [LARGURA-1:0] estagio1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estagio1 <= '0;
            saida    <= '0;
        end else begin
            estagio1 <= entrada;
            saida    <= estagio1;
        end
    end

endmodule

// File: rtl/playseq_detector_jogada.sv
// rtl/playseq_detector_jogada.sv - button synchronizer, debouncer and single-press pulse generator
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   botoes         raw active-high buttons
//   limpa          synchronous clear of jogada/erro_multiplo; forces wait-for-release
//   tem_jogada     one-cycle pulse, a valid single-button jogada is available
//   jogada         one-hot code of the last valid press
//   erro_multiplo  sticky flag, a stable multi-button press was rejected
//   db_estado      current FSM state for debug display
module playseq_detector_jogada
    import playseq_pkg::*;
#(
    parameter int N_BOTOES        = N_BOTOES_PADRAO,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                limpa,
    output logic                tem_jogada,
    output logic [N_BOTOES-1:0] jogada,
    output logic                erro_multiplo,
    output logic [2:0]          db_estado
);

    localparam int              CW      = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0]   CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

    logic [N_BOTOES-1:0] sinc;
    logic [N_BOTOES-1:0] padrao;
    logic [N_BOTOES-1:0] padrao_menos_um;
    logic [CW-1:0]       cnt;
    logic [2:0]          estado;
    logic [2:0]          proximo;
    logic                um_bit;
    logic                cnt_fim;
    logic                sinc_zero;

    playseq_sincronizador #(
        .LARGURA (N_BOTOES)
    ) u_sinc (
        .clock   (clock),
        .reset   (reset),
        .entrada (botoes),
        .saida   (sinc)
    );

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign padrao_menos_um = padrao - N_BOTOES'(1);
    assign um_bit          = (padrao != '0) && ((padrao & padrao_menos_um) == '0);
    assign cnt_fim         = (cnt == CNT_FIM);
    assign sinc_zero       = (sinc == '0);

    always_comb begin
        proximo = estado;
        case (estado)
            EST_OCIOSO: begin
                if (!sinc_zero) proximo = EST_FILTRA_PRESS;
            end
            EST_FILTRA_PRESS: begin
                if (sinc_zero)
                    proximo = EST_OCIOSO;
                else if (sinc == padrao && cnt_fim)
                    proximo = um_bit ? EST_PULSO : EST_SEGURA;
            end
            EST_PULSO: begin
                proximo = EST_SEGURA;
            end
            EST_SEGURA: begin
                if (sinc_zero) proximo = EST_FILTRA_SOLTA;
            end
            EST_FILTRA_SOLTA: begin
                if (!sinc_zero)
                    proximo = EST_SEGURA;
                else if (cnt_fim)
                    proximo = EST_OCIOSO;
            end
            default: begin
                proximo = EST_OCIOSO;
            end
        endcase
        // A held button at limpa time must be released before it can count.
        if (limpa) proximo = EST_SEGURA;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= EST_OCIOSO;
        else        estado <= proximo;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            padrao        <= '0;
            cnt           <= '0;
            jogada        <= '0;
            erro_multiplo <= '0;
        end else begin
            case (estado)
                EST_OCIOSO: begin
                    if (!sinc_zero) begin
                        padrao <= sinc;
                        cnt    <= '0;
                    end
                end
                EST_FILTRA_PRESS: begin
                    if (!sinc_zero && sinc != padrao) begin
                        padrao <= sinc;
                        cnt    <= '0;
                    end else if (!sinc_zero) begin
                        if (cnt_fim) begin
                            if (!um_bit) erro_multiplo <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                EST_PULSO: begin
                    jogada        <= padrao;
                    erro_multiplo <= 1'b0;
                end
                EST_SEGURA: begin
                    if (sinc_zero) cnt <= '0;
                end
                EST_FILTRA_SOLTA: begin
                    if (sinc_zero && !cnt_fim) cnt <= cnt + CW'(1);
                end
                default: begin
                    cnt <= '0;
                end
            endcase
            // Placed last so it wins even over the PULSO load.
            if (limpa) begin
                jogada        <= '0;
                erro_multiplo <= 1'b0;
            end
        end
    end

    assign tem_jogada = (estado == EST_PULSO);
    assign db_estado  = estado;

endmodule

// File: tb/tb_playseq_detector_jogada.sv
// tb/tb_playseq_detector_jogada.sv - self-checking bench for playseq_detector_jogada
module tb_playseq_detector_jogada;

    localparam int NB = 4;
    localparam int DC = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          limpa = 1'b0;
    logic [NB-1:0] botoes = '0;
    logic          tem_jogada;
    logic [NB-1:0] jogada;
    logic          erro_multiplo;
    logic [2:0]    db_estado;

    int erros  = 0;
    int checks = 0;

    logic [31:0] trilha;
    logic [2:0]  ultimo;

    always #5 clock = ~clock;

    playseq_detector_jogada #(
        .N_BOTOES        (NB),
        .DEBOUNCE_CICLOS (DC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .botoes        (botoes),
        .limpa         (limpa),
        .tem_jogada    (tem_jogada),
        .jogada        (jogada),
        .erro_multiplo (erro_multiplo),
        .db_estado     (db_estado)
    );

    // Advance n falling edges; count pulses, note the first pulse index (1-based),
    // and append each new db_estado value to trilha.
    task automatic rodar(input int n, output int pulsos, output int primeiro);
        pulsos   = 0;
        primeiro = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            if (tem_jogada === 1'b1) begin
                pulsos++;
                if (primeiro < 0) primeiro = i;
            end
            if (db_estado !== ultimo) begin
                trilha = {trilha[27:0], 1'b0, db_estado};
                ultimo = db_estado;
            end
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) @(negedge clock);
        checks++; if (tem_jogada !== 1'b0) begin erros++; $display("FAIL reset_tem_jogada: got %b want 0", tem_jogada); end
        checks++; if (jogada !== 4'b0000) begin erros++; $display("FAIL reset_jogada: got %b want 0000", jogada); end
        checks++; if (erro_multiplo !== 1'b0) begin erros++; $display("FAIL reset_erro: got %b want 0", erro_multiplo); end
        checks++; if (db_estado !== 3'd0) begin erros++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_clean_press;
        int p, f, p2, f2;
        trilha = 32'(db_estado);
        ultimo = db_estado;
        botoes = 4'b0010;
        rodar(20, p, f);
        checks++; if (p !== 1) begin erros++; $display("FAIL clean_pulsos: got %0d want 1", p); end
        checks++; if (f !== DC + 3) begin erros++; $display("FAIL clean_latencia: got %0d want %0d", f, DC + 3); end
        checks++; if (jogada !== 4'b0010) begin erros++; $display("FAIL clean_jogada: got %b want 0010", jogada); end
        botoes = 4'b0000;
        rodar(15, p2, f2);
        checks++; if (p2 !== 0) begin erros++; $display("FAIL clean_soltar_pulsos: got %0d want 0", p2); end
        checks++; if (trilha !== 32'h0001_2340) begin erros++; $display("FAIL clean_trilha: got %h want 00012340", trilha); end
    endtask

    task automatic test_bounce;
        int p, f, tot;
        tot = 0;
        for (int s = 0; s < 6; s++) begin
            botoes = (s % 2 == 0) ? 4'b0100 : 4'b0000;
            rodar(2, p, f);
            tot += p;
        end
        checks++; if (tot !== 0) begin erros++; $display("FAIL bounce_sem_pulso: got %0d want 0", tot); end
        botoes = 4'b0100;
        rodar(20, p, f);
        checks++; if (p !== 1) begin erros++; $display("FAIL bounce_pulsos: got %0d want 1", p); end
        checks++; if (f !== DC + 3) begin erros++; $display("FAIL bounce_latencia: got %0d want %0d", f, DC + 3); end
        checks++; if (jogada !== 4'b0100) begin erros++; $display("FAIL bounce_jogada: got %b want 0100", jogada); end
        botoes = 4'b0000;
        rodar(15, p, f);
    endtask

    task automatic test_multi;
        int p, f;
        botoes = 4'b0011;
        rodar(10, p, f);
        checks++; if (p !== 0) begin erros++; $display("FAIL multi_pulsos: got %0d want 0", p); end
        checks++; if (erro_multiplo !== 1'b1) begin erros++; $display("FAIL multi_erro: got %b want 1", erro_multiplo); end
        checks++; if (jogada !== 4'b0100) begin erros++; $display("FAIL multi_jogada_mantida: got %b want 0100", jogada); end
        botoes = 4'b0000;
        rodar(15, p, f);
        checks++; if (erro_multiplo !== 1'b1) begin erros++; $display("FAIL multi_erro_pegajoso: got %b want 1", erro_multiplo); end
        botoes = 4'b1000;
        rodar(20, p, f);
        checks++; if (p !== 1 || f !== DC + 3) begin erros++; $display("FAIL multi_depois_pulso: got %0d at %0d want 1 at %0d", p, f, DC + 3); end
        checks++; if (jogada !== 4'b1000) begin erros++; $display("FAIL multi_depois_jogada: got %b want 1000", jogada); end
        checks++; if (erro_multiplo !== 1'b0) begin erros++; $display("FAIL multi_depois_erro: got %b want 0", erro_multiplo); end
        botoes = 4'b0000;
        rodar(15, p, f);
    endtask

    task automatic test_held;
        int p, f;
        botoes = 4'b0001;
        rodar(100, p, f);
        checks++; if (p !== 1) begin erros++; $display("FAIL held_pulsos: got %0d want 1", p); end
        botoes = 4'b0000;
        rodar(3, p, f);
        botoes = 4'b0001;
        rodar(20, p, f);
        checks++; if (p !== 0) begin erros++; $display("FAIL held_soltura_curta: got %0d want 0", p); end
        checks++; if (db_estado !== 3'd3) begin erros++; $display("FAIL held_estado: got %0d want 3", db_estado); end
        botoes = 4'b0000;
        rodar(10, p, f);
        botoes = 4'b0001;
        rodar(20, p, f);
        checks++; if (p !== 1 || f !== DC + 3) begin erros++; $display("FAIL held_segundo_pulso: got %0d at %0d want 1 at %0d", p, f, DC + 3); end
        botoes = 4'b0000;
        rodar(15, p, f);
    endtask

    task automatic test_limpa;
        int p, f, tot;
        botoes = 4'b0010;
        rodar(4, p, f);
        tot = p;
        limpa = 1'b1;
        rodar(1, p, f);
        tot += p;
        limpa = 1'b0;
        rodar(20, p, f);
        tot += p;
        checks++; if (tot !== 0) begin erros++; $display("FAIL limpa_sem_pulso: got %0d want 0", tot); end
        checks++; if (jogada !== 4'b0000) begin erros++; $display("FAIL limpa_jogada: got %b want 0000", jogada); end
        checks++; if (db_estado !== 3'd3) begin erros++; $display("FAIL limpa_estado: got %0d want 3", db_estado); end
        botoes = 4'b0000;
        rodar(15, p, f);
        // limpa arriving exactly while the FSM sits in PULSO
        botoes = 4'b0100;
        rodar(DC + 3, p, f);
        checks++; if (p !== 1 || tem_jogada !== 1'b1) begin erros++; $display("FAIL limpa_pulso_visto: got %0d/%b want 1/1", p, tem_jogada); end
        limpa = 1'b1;
        rodar(1, p, f);
        limpa = 1'b0;
        checks++; if (jogada !== 4'b0000) begin erros++; $display("FAIL limpa_no_pulso_jogada: got %b want 0000", jogada); end
        botoes = 4'b0000;
        rodar(15, p, f);
        botoes = 4'b0010;
        rodar(20, p, f);
        checks++; if (p !== 1 || jogada !== 4'b0010) begin erros++; $display("FAIL limpa_nova_jogada: got %0d/%b want 1/0010", p, jogada); end
        botoes = 4'b0000;
        rodar(15, p, f);
    endtask

    task automatic test_reset_mid;
        int p, f;
        botoes = 4'b0001;
        rodar(4, p, f);
        checks++; if (db_estado !== 3'd1) begin erros++; $display("FAIL rmid_filtra: got %0d want 1", db_estado); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({tem_jogada, jogada, erro_multiplo, db_estado} !== 9'd0) begin
            erros++; $display("FAIL rmid_async: got tem=%b jog=%b err=%b est=%0d want all 0", tem_jogada, jogada, erro_multiplo, db_estado);
        end
        rodar(3, p, f);
        reset = 1'b1;
        rodar(12, p, f);
        checks++; if (p !== 1 || f !== DC + 3) begin erros++; $display("FAIL rmid_pulso: got %0d at %0d want 1 at %0d", p, f, DC + 3); end
        checks++; if (jogada !== 4'b0001) begin erros++; $display("FAIL rmid_jogada: got %b want 0001", jogada); end
        botoes = 4'b0000;
        rodar(15, p, f);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi();
        test_held();
        test_limpa();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
